// File: rtl/mux_sel_pkg.sv
// Shared types and defaults for the round-robin mux select scanner.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OUT
    } state_t;

    typedef logic [1:0] chan_t;

    localparam int WORD_W_DEF = 8;

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way rotating-priority picker: the first set request at or
// above P (wrapping 3->0) wins.
module rr_arb4
    import mux_sel_pkg::*;
(
    input  logic [3:0] Req,
    input  chan_t      P,
    output logic [3:0] grant,
    output chan_t      chan,
    output logic       any
);

    always_comb begin
        chan_t idx;
        // NOTE: every output gets a default first so no path leaves a latch.
        grant = '0;
        chan  = '0;
        any   = 1'b0;
        idx   = P;
        for (int k = 0; k < 4; k++) begin
            idx = P + chan_t'(k);
            if (!any && Req[idx]) begin
                any         = 1'b1;
                chan        = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_scanner.sv
// Round-robin scanner: grants one channel of a 4:1 mux, shifts WORD_W serial
// bits in, presents the word with valid/ready. Parity gated by MUX_SEL_PARITY_EN.
module mux_sel_scanner
    import mux_sel_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [3:0]        Req,
    input  logic              Mux_out,
    input  logic              Ready,
    output logic              Sel1,
    output logic              Sel0,
    output logic [3:0]        Grant,
    output logic [WORD_W-1:0] Data_out,
    output logic [1:0]        Ch_out,
    output logic              Valid,
    output logic              Parity
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    state_t            state;
    state_t            state_nxt;
    chan_t             ptr;
    chan_t             sel;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] word_nxt;
    logic              last_bit;
    logic [3:0]        arb_grant;
    chan_t             arb_chan;
    logic              arb_any;

    rr_arb4 u_arb (
        .Req   (Req),
        .P     (ptr),
        .grant (arb_grant),
        .chan  (arb_chan),
        .any   (arb_any)
    );

    assign word_nxt = {shreg[WORD_W-2:0], Mux_out};
    assign last_bit = (cnt == CNT_W'(WORD_W - 1));
    assign Sel1     = sel[1];
    assign Sel0     = sel[0];
    assign Valid    = (state == OUT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any)  state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = OUT;
            OUT:     if (Ready)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state <= state_nxt;
        end
    end

    // Requests are only looked at in IDLE; SHIFT/OUT always run to completion.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr      <= '0;
            sel      <= '0;
            Grant    <= '0;
            Ch_out   <= '0;
            cnt      <= '0;
            shreg    <= '0;
            Data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        Grant  <= arb_grant;
                        sel    <= arb_chan;
                        Ch_out <= arb_chan;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    shreg <= word_nxt;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) Data_out <= word_nxt;
                end
                OUT: begin
                    if (Ready) begin
                        Grant <= '0;
                        ptr   <= Ch_out + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MUX_SEL_PARITY_EN
    logic parity_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            parity_q <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            parity_q <= ^word_nxt;
        end
    end

    assign Parity = parity_q;
`else
    assign Parity = 1'b0;
`endif

endmodule
